uart_packet_framer_tx: RTL and testbench

//  Transmit-side packet framer for the UART link. Takes a payload (identifier byte + data bytes), appends
//  a running-XOR checksum, wraps it in HEADER/FOOTER and feeds a byte-level UART TX one byte at a time.

---
 rtl/uart_pkt_pkg.sv | 28 ++
 rtl/uart_packet_framer_tx_if.sv | 16 +
 rtl/uart_packet_framer_tx.sv | 160 ++++++++++++++++
 tb/tb_uart_packet_framer_tx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet link. Both the transmit framer and
// the packet receiver import this package, so the two ends agree on the
// framing bytes and the error codes.
//   HEADER / FOOTER  : framing bytes; HEADER is also the checksum seed
//   IDENTIFIER       : required low nibble of payload byte0
//   TIMEOUT_CYCLES   : max clocks to wait for the UART TX byte-done pulse
//   ERR_*            : 2-bit error codes carried on o_error
//   tx_state_e       : framer FSM encoding
package uart_pkt_pkg;

    localparam logic [7:0]  HEADER         = 8'hAA;
    localparam logic [7:0]  FOOTER         = 8'h55;
    localparam logic [3:0]  IDENTIFIER     = 4'hC;
    localparam logic [31:0] TIMEOUT_CYCLES = 32'd18000;

    // ERR_CHECKSUM doubles as "bad identifier" on the transmit side.
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] ERR_FOOTER   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_packet_framer_tx_if.sv
// Byte-level link between the packet framer and the external UART TX.
//   uart_tx_data : byte to serialize
//   uart_tx_dv   : 1-cycle strobe, uart_tx_data valid on that cycle
//   uart_tx_done : 1-cycle pulse from the UART TX, current byte finished
// Handshake: the master issues one dv strobe per byte and then issues
// nothing more until the slave returns exactly one done pulse for it; there
// is no backpressure other than withholding done. A done pulse that arrives
// while the master is not waiting is dropped.
interface uart_packet_framer_tx_if;
    logic [7:0] uart_tx_data;
    logic       uart_tx_dv;
    logic       uart_tx_done;

    modport master (output uart_tx_data, output uart_tx_dv, input  uart_tx_done);
    modport slave  (input  uart_tx_data, input  uart_tx_dv, output uart_tx_done);
endinterface

// File: rtl/uart_packet_framer_tx.sv
// Transmit-side packet framer. Sends HEADER, the payload bytes (identifier
// first), a running-XOR checksum seeded with HEADER, and FOOTER to the UART TX
// one byte at a time, waiting for the byte-done pulse between bytes.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : enable; when low the FSM and all state hold
//   i_start        : frame request, sampled only in IDLE
//   i_payload      : (TX_PACKET_LEN-1) bytes, byte k at [8k+7:8k]
//   o_busy         : frame in progress
//   o_done         : 1-cycle pulse when the footer has been accepted
//   o_error        : last error code (held), o_error_dv qualifies it
//   o_dbg_state    : current FSM state
//   uart           : byte link to the UART TX (master side)
module uart_packet_framer_tx
    import uart_pkt_pkg::*;
#(
    parameter int TX_PACKET_LEN = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_en,
    input  logic                           i_start,
    input  logic [(TX_PACKET_LEN-1)*8-1:0] i_payload,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [1:0]                     o_error,
    output logic                           o_error_dv,
    output tx_state_e                      o_dbg_state,
    uart_packet_framer_tx_if.master        uart
);

    localparam int PAY_W = (TX_PACKET_LEN - 1) * 8;
    localparam int IDX_W = $clog2(TX_PACKET_LEN + 2);

    localparam logic [IDX_W-1:0] IDX_CSUM   = IDX_W'(TX_PACKET_LEN);
    localparam logic [IDX_W-1:0] IDX_FOOTER = IDX_W'(TX_PACKET_LEN + 1);

    tx_state_e        state_q,   state_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic [31:0]      tmo_q,     tmo_d;
    logic [PAY_W-1:0] shreg_q,   shreg_d;
    logic [7:0]       csum_q,    csum_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [1:0]       err_q,     err_d;
    logic             err_dv_q,  err_dv_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_dv_q,   tx_dv_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= TX_IDLE;
            idx_q     <= '0;
            tmo_q     <= '0;
            shreg_q   <= '0;
            csum_q    <= HEADER;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= ERR_NONE;
            err_dv_q  <= 1'b0;
            tx_data_q <= '0;
            tx_dv_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            shreg_q   <= shreg_d;
            csum_q    <= csum_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_dv_q  <= err_dv_d;
            tx_data_q <= tx_data_d;
            tx_dv_q   <= tx_dv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        shreg_d   = shreg_q;
        csum_d    = csum_q;
        busy_d    = busy_q;
        err_d     = err_q;
        tx_data_d = tx_data_q;
        // Pulses default low every cycle, which also forces them low while
        // the block is disabled.
        done_d    = 1'b0;
        err_dv_d  = 1'b0;
        tx_dv_d   = 1'b0;

        if (i_en) begin
            unique case (state_q)
                TX_IDLE: begin
                    if (i_start) begin
                        if (i_payload[3:0] == IDENTIFIER) begin
                            shreg_d = i_payload;
                            csum_d  = HEADER;
                            idx_d   = '0;
                            busy_d  = 1'b1;
                            state_d = TX_SEND;
                        end else begin
                            err_d    = ERR_CHECKSUM;
                            err_dv_d = 1'b1;
                        end
                    end
                end
                TX_SEND: begin
                    tx_dv_d = 1'b1;
                    tmo_d   = '0;
                    state_d = TX_WAIT;
                    if (idx_q == '0) begin
                        tx_data_d = HEADER;
                    end else if (idx_q < IDX_CSUM) begin
                        // Payload bytes leave from the bottom of the shift
                        // register; the checksum folds in each one as sent.
                        tx_data_d = shreg_q[7:0];
                        shreg_d   = shreg_q >> 8;
                        csum_d    = csum_q ^ shreg_q[7:0];
                    end else if (idx_q == IDX_CSUM) begin
                        tx_data_d = csum_q;
                    end else begin
                        tx_data_d = FOOTER;
                    end
                end
                TX_WAIT: begin
                    // done has priority over a coincident timeout.
                    if (uart.uart_tx_done) begin
                        if (idx_q == IDX_FOOTER) begin
                            state_d = TX_IDLE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = TX_SEND;
                        end
                    end else if (tmo_q > TIMEOUT_CYCLES) begin
                        state_d  = TX_IDLE;
                        busy_d   = 1'b0;
                        err_d    = ERR_TIMEOUT;
                        err_dv_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end
                default: state_d = TX_IDLE;
            endcase
        end
    end

    assign o_busy            = busy_q;
    assign o_done            = done_q;
    assign o_error           = err_q;
    assign o_error_dv        = err_dv_q;
    assign o_dbg_state       = state_q;
    assign uart.uart_tx_data = tx_data_q;
    assign uart.uart_tx_dv   = tx_dv_q;

endmodule

// File: tb/tb_uart_packet_framer_tx.sv
module tb_uart_packet_framer_tx;
    import uart_pkt_pkg::*;

    localparam int LEN = 4;
    localparam int PW  = (LEN - 1) * 8;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          start;
    logic [PW-1:0] payload;
    logic          busy;
    logic          done;
    logic [1:0]    error;
    logic          error_dv;
    tx_state_e     dbg_state;

    uart_packet_framer_tx_if u_if ();

    uart_packet_framer_tx #(.TX_PACKET_LEN(LEN)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_start     (start),
        .i_payload   (payload),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (error),
        .o_error_dv  (error_dv),
        .o_dbg_state (dbg_state),
        .uart        (u_if.master)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         hold_at       = -1;
    int         kick_cnt      = 0;
    int         done_cnt      = 0;
    int         errdv_cnt     = 0;
    int         busy_low_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART TX model: captures each strobed byte and returns done 10 cycles
    // later, unless the byte count hits hold_at. kick_cnt forces one done.
    initial begin
        int pend      = 0;
        int kick_seen = 0;
        u_if.uart_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            u_if.uart_tx_done = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else if (u_if.uart_tx_dv) begin
                got_q.push_back(u_if.uart_tx_data);
                if (!busy) busy_low_cnt++;
                pend = (got_q.size() != hold_at) ? 10 : 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) u_if.uart_tx_done = 1'b1;
            end
            if (kick_cnt != kick_seen) begin
                kick_seen = kick_cnt;
                u_if.uart_tx_done = 1'b1;
            end
            if (done)     done_cnt++;
            if (error_dv) errdv_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input logic [PW-1:0] p);
        payload = p;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (u_if.uart_tx_dv) seen++;
        end
        check("wait_strobes", seen, n);
    endtask

    task automatic wait_done(input int budget);
        int cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("wait_done", {31'd0, done}, 32'd1);
    endtask

    // Reference frame: header, payload bytes, XOR checksum seeded by header, footer.
    task automatic build_exp(input logic [PW-1:0] p);
        logic [7:0] cs;
        logic [7:0] b;
        exp_q.delete();
        exp_q.push_back(8'hAA);
        cs = 8'hAA;
        for (int i = 0; i < LEN - 1; i++) begin
            b = p[8*i +: 8];
            exp_q.push_back(b);
            cs = cs ^ b;
        end
        exp_q.push_back(cs);
        exp_q.push_back(8'h55);
    endtask

    task automatic check_frame(input string tag, input int base);
        check($sformatf("%s_len", tag), got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size())
                check($sformatf("%s_b%0d", tag, i), {24'd0, got_q[base+i]}, {24'd0, exp_q[i]});
        end
    endtask

    task automatic run_frame(input string tag, input logic [PW-1:0] p);
        int base = got_q.size();
        int d0   = done_cnt;
        build_exp(p);
        pulse_start(p);
        wait_done(500);
        repeat (3) @(negedge clk);
        check_frame(tag, base);
        check($sformatf("%s_done_cnt", tag), done_cnt - d0, 1);
        check($sformatf("%s_busy_end", tag), {31'd0, busy}, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int d0;
        int e0;
        int k0;
        int cyc;
        logic [7:0] x;

        rst_n   = 1'b0;
        en      = 1'b1;
        start   = 1'b0;
        payload = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",    {31'd0, busy}, 0);
        check("rst_done",    {31'd0, done}, 0);
        check("rst_error",   {30'd0, error}, 0);
        check("rst_err_dv",  {31'd0, error_dv}, 0);
        check("rst_tx_dv",   {31'd0, u_if.uart_tx_dv}, 0);
        check("rst_tx_data", {24'd0, u_if.uart_tx_data}, 0);
        check("rst_state",   {30'd0, dbg_state}, {30'd0, TX_IDLE});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Frame 1 with start-to-header latency: wire AA 0C 12 34 80 55
        base = got_q.size();
        d0   = done_cnt;
        build_exp(24'h34120C);
        check("t1_csum_ref", {24'd0, exp_q[4]}, 32'h80);
        pulse_start(24'h34120C);
        check("t1_busy_after_start", {31'd0, busy}, 1);
        check("t1_no_dv_yet",        {31'd0, u_if.uart_tx_dv}, 0);
        @(negedge clk);
        check("t1_hdr_dv",   {31'd0, u_if.uart_tx_dv}, 1);
        check("t1_hdr_data", {24'd0, u_if.uart_tx_data}, 32'hAA);
        wait_done(500);
        repeat (3) @(negedge clk);
        check_frame("t1", base);
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_busy_during", busy_low_cnt, 0);
        check("t1_busy_end", {31'd0, busy}, 0);
        // Receiver-side view: XOR over header..checksum cancels to zero.
        x = 8'h00;
        for (int i = 0; i < 5; i++) x = x ^ got_q[base+i];
        check("t1_loopback_xor", {24'd0, x}, 0);

        // Second pattern: AA DC 00 FF 89 55
        build_exp(24'hFF00DC);
        check("t1b_csum_ref", {24'd0, exp_q[4]}, 32'h89);
        run_frame("t1b", 24'hFF00DC);

        // Bad identifier
        base = got_q.size();
        e0   = errdv_cnt;
        pulse_start(24'h00000B);
        check("t3_error",    {30'd0, error}, 32'h1);
        check("t3_error_dv", {31'd0, error_dv}, 1);
        check("t3_busy",     {31'd0, busy}, 0);
        repeat (30) @(negedge clk);
        check("t3_no_bytes", got_q.size() - base, 0);
        check("t3_errdv_cnt", errdv_cnt - e0, 1);

        // Timeout after byte 2 (third strobe): error_dv lands T+2 cycles after that strobe
        base    = got_q.size();
        hold_at = base + 3;
        pulse_start(24'h56341C);
        wait_strobes(3, 200);
        cyc = 0;
        while (!error_dv && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_tmo_cycles", cyc, 32'd18002);
        check("t4_error", {30'd0, error}, 32'h3);
        check("t4_busy",  {31'd0, busy}, 0);
        repeat (30) @(negedge clk);
        check("t4_no_footer", got_q.size() - base, 3);
        if (got_q.size() > 0)
            check("t4_last_byte", {24'd0, got_q[got_q.size()-1]}, 32'h34);
        hold_at = -1;
        run_frame("t4_after", 24'h34120C);

        // Start re-pulsed mid-frame, then reset after the third byte
        base = got_q.size();
        pulse_start(24'h34120C);
        wait_strobes(2, 200);
        pulse_start(24'h00001C);
        wait_strobes(1, 200);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy",    {31'd0, busy}, 0);
        check("t5_rst_done",    {31'd0, done}, 0);
        check("t5_rst_error",   {30'd0, error}, 0);
        check("t5_rst_err_dv",  {31'd0, error_dv}, 0);
        check("t5_rst_tx_dv",   {31'd0, u_if.uart_tx_dv}, 0);
        check("t5_rst_tx_data", {24'd0, u_if.uart_tx_data}, 0);
        check("t5_rst_state",   {30'd0, dbg_state}, {30'd0, TX_IDLE});
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_bytes_len", got_q.size() - base, 3);
        if (got_q.size() >= base + 3) begin
            check("t5_b0", {24'd0, got_q[base]},   32'hAA);
            check("t5_b1", {24'd0, got_q[base+1]}, 32'h0C);
            check("t5_b2", {24'd0, got_q[base+2]}, 32'h12);
        end
        run_frame("t5_after", 24'hFF00DC);

        // Enable low during WAIT with a done pulse while disabled
        base    = got_q.size();
        d0      = done_cnt;
        hold_at = base + 2;
        build_exp(24'h34120C);
        pulse_start(24'h34120C);
        wait_strobes(2, 200);
        repeat (3) @(negedge clk);
        en = 1'b0;
        k0 = got_q.size();
        kick_cnt++;
        repeat (50) @(negedge clk);
        check("t6_busy_held",  {31'd0, busy}, 1);
        check("t6_state_held", {30'd0, dbg_state}, {30'd0, TX_WAIT});
        check("t6_no_strobe",  got_q.size() - k0, 0);
        en = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_done_ignored", got_q.size() - k0, 0);
        hold_at = -1;
        kick_cnt++;
        wait_done(500);
        repeat (3) @(negedge clk);
        check_frame("t6", base);
        check("t6_done_cnt", done_cnt - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
